// File: rtl/boot_pkg.sv
// Shared definitions for the byte-stream boot loaders: FSM encoding,
// default frame marker and the byte positions of the frame header fields.
package boot_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CNT0,
        CNT1,
        BASE0,
        BASE1,
        DATA,
        WAIT_WR,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam int OFF_MAGIC   = 0;
    localparam int OFF_CNT_LO  = 1;
    localparam int OFF_CNT_HI  = 2;
    localparam int OFF_BASE_LO = 3;
    localparam int OFF_BASE_HI = 4;
    localparam int OFF_DATA    = 5;

    // True while a frame is being parsed (the states guarded by the timeout).
    function automatic logic in_frame(state_t s);
        return !(s inside {IDLE, DONE, ERR});
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry on the LIMIT-th consecutive cycle without a clear.
module loader_timeout #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    assign expire = en && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || !en) begin
            cnt_q <= '0;
        end else if (!expire) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/iram_loader.sv
// Instruction-RAM boot loader: parses a MAGIC/CNT/BASE/data/CSUM byte frame,
// writes one little-endian 32-bit word per four data bytes and holds the core.
module iram_loader
    import boot_pkg::*;
#(
    parameter int         DEPTH_WORDS = 8191,
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
    parameter int         TIMEOUT     = 1000000,
    parameter bit         BOOT_HOLD   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        iram_we,
    output logic [31:0] iram_waddr,
    output logic [31:0] iram_wdata,
    output logic        core_hold,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err
);

    state_t state_q, state_d;

    logic [15:0] cnt_q;
    logic [7:0]  base_lo_q;
    logic [15:0] addr_q;
    logic [15:0] wcount_q;
    logic [1:0]  idx_q;
    logic [31:0] word_buf_q;
    logic [7:0]  csum_q;

    logic        accept;
    logic        start;
    logic        tmo_expire;
    logic [16:0] range_end;
    logic        range_bad;
    logic        last_word;

    assign byte_ready = (state_q != WAIT_WR);
    assign accept     = byte_valid && byte_ready;
    assign start      = accept && (byte_data == MAGIC) && !in_frame(state_q);

    // 17-bit sum so BASE+CNT past the 16-bit range still compares correctly.
    assign range_end  = {1'b0, byte_data, base_lo_q} + {1'b0, cnt_q};
    assign range_bad  = range_end > 17'(DEPTH_WORDS);
    assign last_word  = (wcount_q + 16'd1) == cnt_q;

    loader_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (in_frame(state_q)),
        .expire(tmo_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = CNT0;
            CNT0:    if (accept) state_d = CNT1;
            CNT1:    if (accept) state_d = BASE0;
            BASE0:   if (accept) state_d = BASE1;
            BASE1: begin
                if (accept) begin
                    if (range_bad)          state_d = ERR;
                    else if (cnt_q == 16'd0) state_d = CSUM;
                    else                    state_d = DATA;
                end
            end
            DATA:    if (accept && idx_q == 2'd3) state_d = WAIT_WR;
            WAIT_WR: state_d = last_word ? CSUM : DATA;
            CSUM:    if (accept) state_d = (byte_data == csum_q) ? DONE : ERR;
            default: state_d = IDLE;
        endcase
        if (tmo_expire && !accept) state_d = ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            base_lo_q  <= '0;
            addr_q     <= '0;
            wcount_q   <= '0;
            idx_q      <= '0;
            word_buf_q <= '0;
            csum_q     <= '0;
            iram_we    <= 1'b0;
            iram_waddr <= '0;
            iram_wdata <= '0;
            core_hold  <= BOOT_HOLD;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            iram_we   <= 1'b0;
            load_done <= 1'b0;

            if (accept) begin
                case (state_q)
                    CNT0:  cnt_q[7:0]  <= byte_data;
                    CNT1:  cnt_q[15:8] <= byte_data;
                    BASE0: base_lo_q   <= byte_data;
                    BASE1: begin
                        addr_q   <= {byte_data, base_lo_q};
                        wcount_q <= '0;
                        idx_q    <= '0;
                    end
                    DATA: begin
                        word_buf_q[8*idx_q +: 8] <= byte_data;
                        csum_q <= csum_q ^ byte_data;
                        idx_q  <= idx_q + 2'd1;
                        // Fourth byte completes the word; present it on the write port now.
                        if (idx_q == 2'd3) begin
                            iram_we    <= 1'b1;
                            iram_waddr <= {16'd0, addr_q};
                            iram_wdata <= {byte_data, word_buf_q[23:0]};
                        end
                    end
                    default: ;
                endcase
            end

            if (state_q == WAIT_WR) begin
                addr_q   <= addr_q + 16'd1;
                wcount_q <= wcount_q + 16'd1;
            end

            if (start) begin
                load_err  <= 1'b0;
                csum_q    <= '0;
                core_hold <= 1'b1;
                load_busy <= 1'b1;
            end

            if (state_q == CSUM && state_d == DONE) begin
                load_done <= 1'b1;
                load_busy <= 1'b0;
                core_hold <= 1'b0;
            end

            if (state_d == ERR && state_q != ERR) begin
                load_err  <= 1'b1;
                load_busy <= 1'b0;
            end
        end
    end

endmodule
